// File: rtl/cisc_bus_pkg.sv
// Shared types and strobe-level constants for the CISC-style bus cycle sequencer.
package cisc_bus_pkg;

    // Bus cycle phases. TW repeats while the external device holds READY low.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_T3   = 3'd3,
        ST_TW   = 3'd4,
        ST_T4   = 3'd5
    } bus_state_e;

    // Strobes rd_, wr_ and den_ are active-low.
    localparam logic STROBE_ACTIVE = 1'b0;
    localparam logic STROBE_IDLE   = 1'b1;

    // dtr_ selects the external transceiver direction.
    localparam logic DTR_TRANSMIT = 1'b1;
    localparam logic DTR_RECEIVE  = 1'b0;

    // Phases in which the command strobe and data enable are asserted.
    function automatic logic in_strobe_phase(input bus_state_e s);
        return (s == ST_T2) || (s == ST_T3) || (s == ST_TW);
    endfunction

endpackage

// File: rtl/bus_cycle_sequencer_if.sv
// Request/response handshake plus external bus pins of the sequencer.
// master = the sequencer (it owns the external bus), slave = its environment.
interface bus_cycle_sequencer_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic              bus_ready;
    logic [DATA_W-1:0] bus_din;
    logic [ADDR_W-1:0] addr_out;
    logic [DATA_W-1:0] data_out;
    logic              data_oe;
    logic              ale;
    logic              rd_;
    logic              wr_;
    logic              den_;
    logic              dtr_;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, bus_ready, bus_din,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               addr_out, data_out, data_oe, ale, rd_, wr_, den_, dtr_
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, bus_ready, bus_din,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               addr_out, data_out, data_oe, ale, rd_, wr_, den_, dtr_
    );
endinterface

// File: rtl/bus_wait_timer.sv
// Counts consecutive wait states and flags when the configured limit is reached.
// WAIT_LIMIT = 0 disables the limit flag entirely.
module bus_wait_timer #(
    parameter int WAIT_LIMIT = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic limit_hit
);
    localparam int                CNT_W     = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;
    localparam logic [CNT_W-1:0]  LIMIT_VAL = CNT_W'(WAIT_LIMIT);

    logic [CNT_W-1:0] count;

    // Wait-state counter: cleared outside TW, saturates rather than wrapping.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst || clear) begin
            count <= '0;
        end else if (enable && (count != {CNT_W{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

    assign limit_hit = (WAIT_LIMIT > 0) && (count == LIMIT_VAL);

endmodule

// File: rtl/bus_cycle_sequencer.sv
// Sequences T1..T4 bus cycles (with TW wait states and timeout) for an execution
// unit request. All bus strobes are registered from the next state, so they change
// only at clock edges and line up exactly with the phase they belong to.
module bus_cycle_sequencer
    import cisc_bus_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int DATA_W     = 16,
    parameter int WAIT_LIMIT = 15
) (
    input  logic                 clk,
    input  logic                 rst,
    bus_cycle_sequencer_if.master bus
);
    bus_state_e        state;
    bus_state_e        state_nxt;
    logic              accept;
    logic              write_q;
    logic              write_cur;
    logic              limit_hit;
    logic              timeout;

    logic              req_ready_q;
    logic              ale_q;
    logic              rd_q;
    logic              wr_q;
    logic              den_q;
    logic              dtr_q;
    logic              data_oe_q;
    logic              rsp_valid_q;
    logic              rsp_err_q;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    assign accept    = bus.req_valid && req_ready_q;
    // Direction of the cycle being entered: a fresh request overrides the latched one.
    assign write_cur = accept ? bus.req_write : write_q;
    // Wait limit reached while the device still holds READY low.
    assign timeout   = (state == ST_TW) && !bus.bus_ready && limit_hit;

    // Next-state decode for the bus cycle phases.
    always_comb begin
        // NOTE: default assignment first so every path drives state_nxt and no latch is inferred.
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (accept) state_nxt = ST_T1;
            ST_T1:   state_nxt = ST_T2;
            ST_T2:   state_nxt = ST_T3;
            ST_T3:   state_nxt = bus.bus_ready ? ST_T4 : ST_TW;
            ST_TW:   if (bus.bus_ready || limit_hit) state_nxt = ST_T4;
            ST_T4:   state_nxt = accept ? ST_T1 : ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    bus_wait_timer #(
        .WAIT_LIMIT (WAIT_LIMIT)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .clear     (state_nxt != ST_TW),
        .enable    (state_nxt == ST_TW),
        .limit_hit (limit_hit)
    );

    // Phase register, registered strobes, request latches and read-data capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            req_ready_q <= 1'b1;
            ale_q       <= 1'b0;
            rd_q        <= STROBE_IDLE;
            wr_q        <= STROBE_IDLE;
            den_q       <= STROBE_IDLE;
            dtr_q       <= DTR_TRANSMIT;
            data_oe_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
        end else begin
            state       <= state_nxt;
            req_ready_q <= (state_nxt == ST_IDLE) || (state_nxt == ST_T4);
            ale_q       <= (state_nxt == ST_T1);
            rd_q        <= (in_strobe_phase(state_nxt) && !write_cur) ? STROBE_ACTIVE : STROBE_IDLE;
            wr_q        <= (in_strobe_phase(state_nxt) &&  write_cur) ? STROBE_ACTIVE : STROBE_IDLE;
            den_q       <= in_strobe_phase(state_nxt) ? STROBE_ACTIVE : STROBE_IDLE;
            data_oe_q   <= write_cur && (in_strobe_phase(state_nxt) || (state_nxt == ST_T4));
            rsp_valid_q <= (state_nxt == ST_T4);
            rsp_err_q   <= timeout;

            // Transceiver direction is only driven during a cycle; it parks when idle.
            if (state_nxt != ST_IDLE) begin
                dtr_q <= write_cur ? DTR_TRANSMIT : DTR_RECEIVE;
            end

            if (accept) begin
                addr_q  <= bus.req_addr;
                wdata_q <= bus.req_wdata;
                write_q <= bus.req_write;
            end

            // Read data is taken on the edge that completes the data phase normally.
            if (((state == ST_T3) || (state == ST_TW)) && bus.bus_ready && !write_q) begin
                rsp_rdata_q <= bus.bus_din;
            end
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.ale       = ale_q;
    assign bus.rd_       = rd_q;
    assign bus.wr_       = wr_q;
    assign bus.den_      = den_q;
    assign bus.dtr_      = dtr_q;
    assign bus.data_oe   = data_oe_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.addr_out  = addr_q;
    assign bus.data_out  = wdata_q;

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Bench for bus_cycle_sequencer: two instances (long and short wait limit) share
// stimulus; each transaction's expected waveform is derived from its phase timeline.
module tb_bus_cycle_sequencer;
    localparam int ADDR_W  = 16;
    localparam int DATA_W  = 16;
    localparam int LIMIT_A = 15;
    localparam int LIMIT_B = 2;

    typedef struct {
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [DATA_W-1:0] din;
        int                n_wait;   // cycles READY is held low starting in T3
    } txn_t;

    logic              clk       = 1'b0;
    logic              rst       = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_write = 1'b0;
    logic [ADDR_W-1:0] req_addr  = '0;
    logic [DATA_W-1:0] req_wdata = '0;
    logic              bus_ready = 1'b1;
    logic [DATA_W-1:0] bus_din   = '0;
    logic              use_b     = 1'b0;

    int                total = 0;
    int                bad   = 0;
    txn_t              pend[$];
    logic [DATA_W-1:0] rdata_hold [2];
    logic              dtr_hold   [2];

    always #5 clk = ~clk;

    bus_cycle_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifa ();
    bus_cycle_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ifb ();

    bus_cycle_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_LIMIT(LIMIT_A)) dut_a (
        .clk (clk), .rst (rst), .bus (ifa));
    bus_cycle_sequencer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WAIT_LIMIT(LIMIT_B)) dut_b (
        .clk (clk), .rst (rst), .bus (ifb));

    assign ifa.req_valid = req_valid && !use_b;
    assign ifb.req_valid = req_valid &&  use_b;
    assign ifa.req_write = req_write;  assign ifb.req_write = req_write;
    assign ifa.req_addr  = req_addr;   assign ifb.req_addr  = req_addr;
    assign ifa.req_wdata = req_wdata;  assign ifb.req_wdata = req_wdata;
    assign ifa.bus_ready = bus_ready;  assign ifb.bus_ready = bus_ready;
    assign ifa.bus_din   = bus_din;    assign ifb.bus_din   = bus_din;

    // {req_ready, ale, rd_, wr_, den_, dtr_, data_oe, rsp_valid}
    logic [7:0]        ctl_a, ctl_b, obs_ctl;
    logic              obs_err;
    logic [DATA_W-1:0] obs_rdata, obs_dout;
    logic [ADDR_W-1:0] obs_addr;
    assign ctl_a = {ifa.req_ready, ifa.ale, ifa.rd_, ifa.wr_, ifa.den_, ifa.dtr_, ifa.data_oe, ifa.rsp_valid};
    assign ctl_b = {ifb.req_ready, ifb.ale, ifb.rd_, ifb.wr_, ifb.den_, ifb.dtr_, ifb.data_oe, ifb.rsp_valid};
    assign obs_ctl   = use_b ? ctl_b         : ctl_a;
    assign obs_err   = use_b ? ifb.rsp_err   : ifa.rsp_err;
    assign obs_rdata = use_b ? ifb.rsp_rdata : ifa.rsp_rdata;
    assign obs_dout  = use_b ? ifb.data_out  : ifa.data_out;
    assign obs_addr  = use_b ? ifb.addr_out  : ifa.addr_out;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic select(input logic b);
        use_b = b;
        #1;
    endtask

    function automatic txn_t mk(input logic wr, input logic [ADDR_W-1:0] addr,
                                input logic [DATA_W-1:0] data, input logic [DATA_W-1:0] din,
                                input int n_wait);
        txn_t t;
        t.wr = wr; t.addr = addr; t.data = data; t.din = din; t.n_wait = n_wait;
        return t;
    endfunction

    // Expected control pins in cycle i after acceptance (i=1 is T1) given w wait states.
    function automatic logic [7:0] model_ctl(input int i, input logic wr, input int w);
        logic strobe;
        logic last;
        strobe = (i >= 2) && (i <= 3 + w);
        last   = (i == 4 + w);
        return {last, (i == 1), !(strobe && !wr), !(strobe && wr), !strobe, wr, wr && (i >= 2), last};
    endfunction

    function automatic logic [7:0] idle_ctl(input logic dtr);
        return {1'b1, 1'b0, 1'b1, 1'b1, 1'b1, dtr, 1'b0, 1'b0};
    endfunction

    task automatic issue(input txn_t t);
        req_valid = 1'b1;
        req_write = t.wr;
        req_addr  = t.addr;
        req_wdata = t.data;
    endtask

    // Runs everything queued in pend back-to-back on the selected instance.
    task automatic run_burst();
        txn_t t;
        int   inst;
        int   lim;
        int   w;
        logic tmo;
        logic more;
        inst = use_b ? 1 : 0;
        lim  = use_b ? LIMIT_B : LIMIT_A;
        check("pre_idle", obs_ctl, idle_ctl(dtr_hold[inst]));
        t = pend.pop_front();
        issue(t);
        more = 1'b1;
        while (more) begin
            tmo = (lim > 0) && (t.n_wait > lim);
            w   = tmo ? lim : t.n_wait;
            for (int i = 1; i <= 4 + w; i++) begin
                step();
                req_valid = 1'b0;
                bus_ready = !((i >= 3) && (i < 3 + t.n_wait));
                bus_din   = (bus_ready && (i >= 3)) ? t.din : DATA_W'($urandom);
                check("ctl", obs_ctl, model_ctl(i, t.wr, w));
                if (i == 1) begin
                    check("addr_out", obs_addr, t.addr);
                    check("data_out", obs_dout, t.data);
                end
                if (i == 4 + w) begin
                    if (!t.wr && !tmo) rdata_hold[inst] = t.din;
                    check("rsp_err", obs_err, tmo);
                    check("rsp_rdata", obs_rdata, rdata_hold[inst]);
                end
            end
            dtr_hold[inst] = t.wr;
            if (pend.size() == 0) begin
                more = 1'b0;
            end else begin
                t = pend.pop_front();
                issue(t);
            end
        end
        step();
        req_valid = 1'b0;
        bus_ready = 1'b1;
        check("post_idle", obs_ctl, idle_ctl(dtr_hold[inst]));
    endtask

    // Bus-level safety invariants on both instances throughout the run.
    always @(negedge clk) begin
        if (!rst) begin
            check("rd_wr_excl_a", ifa.rd_ | ifa.wr_, 1);
            check("rd_wr_excl_b", ifb.rd_ | ifb.wr_, 1);
            check("ale_cmd_a", ifa.ale & ~(ifa.rd_ & ifa.wr_), 0);
            check("ale_cmd_b", ifb.ale & ~(ifb.rd_ & ifb.wr_), 0);
        end
    end

    initial begin
        txn_t t;
        int   n;
        int   gap;
        rdata_hold[0] = '0; rdata_hold[1] = '0;
        dtr_hold[0]   = 1'b1; dtr_hold[1] = 1'b1;

        // Reset values on both instances.
        step();
        step();
        for (int s = 0; s < 2; s++) begin
            select(s == 1);
            check("rst_ctl", obs_ctl, idle_ctl(1'b1));
            check("rst_err", obs_err, 0);
            check("rst_rdata", obs_rdata, 0);
            check("rst_addr", obs_addr, 0);
            check("rst_dout", obs_dout, 0);
        end
        select(1'b0);
        rst = 1'b0;
        step();

        // Zero-wait read.
        pend.push_back(mk(1'b0, 16'h1234, 16'h0000, 16'hA5C3, 0));
        run_burst();
        // Write with three wait states.
        pend.push_back(mk(1'b1, 16'h0100, 16'hBEEF, 16'h0000, 3));
        run_burst();
        // Two back-to-back reads.
        pend.push_back(mk(1'b0, 16'h0200, 16'h0000, 16'h1111, 0));
        pend.push_back(mk(1'b0, 16'h0202, 16'h0000, 16'h2222, 0));
        run_burst();

        // Short-limit instance: stuck READY read times out, rdata untouched.
        select(1'b1);
        pend.push_back(mk(1'b0, 16'h4000, 16'h0000, 16'h7777, 50));
        run_burst();
        // Exactly at the limit READY still wins; one beyond times out.
        pend.push_back(mk(1'b0, 16'h4002, 16'h0000, 16'h5A5A, 2));
        pend.push_back(mk(1'b1, 16'h4004, 16'h1357, 16'h0000, 3));
        run_burst();

        // Reset during a write wait state aborts the cycle silently.
        select(1'b0);
        t = mk(1'b1, 16'h0300, 16'hCAFE, 16'h0000, 10);
        check("abort_pre_idle", obs_ctl, idle_ctl(dtr_hold[0]));
        issue(t);
        for (int i = 1; i <= 5; i++) begin
            step();
            req_valid = 1'b0;
            bus_ready = 1'b0;
            check("abort_ctl", obs_ctl, model_ctl(i, 1'b1, 10));
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus_ready = 1'b1;
        rdata_hold[0] = '0; rdata_hold[1] = '0;
        dtr_hold[0]   = 1'b1; dtr_hold[1] = 1'b1;
        check("abort_idle", obs_ctl, idle_ctl(1'b1));
        check("abort_addr", obs_addr, 0);
        check("abort_rdata", obs_rdata, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("abort_quiet", obs_ctl, idle_ctl(1'b1));
        end

        // Randomized bursts on randomly chosen instances.
        for (int b = 0; b < 30; b++) begin
            select(1'($urandom_range(0, 1)));
            n = $urandom_range(1, 3);
            for (int j = 0; j < n; j++) begin
                pend.push_back(mk(1'($urandom), ADDR_W'($urandom), DATA_W'($urandom),
                                  DATA_W'($urandom), $urandom_range(0, 4)));
            end
            run_burst();
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                step();
                check("gap_idle", obs_ctl, idle_ctl(dtr_hold[use_b ? 1 : 0]));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
